// File: rtl/alu_sequencer.sv
// Command front-end for the 32-bit ripple ALU: decodes a 3-bit command into slice
// controls, holds the ALU inputs for SETTLE cycles, then captures result and flags.
module alu_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [2:0]       aluOperation,
  output logic             aluInvertA,
  output logic             aluInvertB,
  output logic             aluCarryin,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluCarryout,
  input  logic             aluOverflow,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       fsm_state
);

  // Handshakes: a command transfers on a rising edge where cmdValid && cmdReady;
  // a response transfers on a rising edge where rspValid && rspReady. Both ready/valid
  // outputs are pure functions of state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] count;
  logic       arith;
  logic       accept;
  logic       capture;

  logic [2:0] dec_op;
  logic       dec_ia;
  logic       dec_ib;
  logic       dec_ci;
  logic       dec_arith;

  assign accept  = (state == S_IDLE) && cmdValid;
  assign capture = (state == S_WAIT) && (count == 8'd0);

  always_comb begin
    dec_op    = 3'd0;
    dec_ia    = 1'b0;
    dec_ib    = 1'b0;
    dec_ci    = 1'b0;
    dec_arith = 1'b0;
    case (command)
      3'd0: dec_arith = 1'b1;
      3'd1: begin dec_ib = 1'b1; dec_ci = 1'b1; dec_arith = 1'b1; end
      3'd2: dec_op = 3'd1;
      3'd3: begin dec_op = 3'd2; dec_ib = 1'b1; dec_ci = 1'b1; dec_arith = 1'b1; end
      3'd4: dec_op = 3'd3;
      3'd5: begin dec_op = 3'd4; dec_ia = 1'b1; dec_ib = 1'b1; end
      3'd6: begin dec_op = 3'd3; dec_ia = 1'b1; dec_ib = 1'b1; end
      default: dec_op = 3'd4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmdValid) state_nxt = S_WAIT;
      S_WAIT:  if (count == 8'd0) state_nxt = S_DONE;
      S_DONE:  if (rspReady) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmdReady  = (state == S_IDLE);
    rspValid  = (state == S_DONE);
    fsm_state = state;
  end

  // ALU inputs only move on accept, so they persist through WAIT, DONE and back into IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluA         <= '0;
      aluB         <= '0;
      aluOperation <= 3'd0;
      aluInvertA   <= 1'b0;
      aluInvertB   <= 1'b0;
      aluCarryin   <= 1'b0;
      arith        <= 1'b0;
      count        <= 8'd0;
    end else if (accept) begin
      aluA         <= operandA;
      aluB         <= operandB;
      aluOperation <= dec_op;
      aluInvertA   <= dec_ia;
      aluInvertB   <= dec_ib;
      aluCarryin   <= dec_ci;
      arith        <= dec_arith;
      count        <= LOAD;
    end else if ((state == S_WAIT) && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // Adder flags are meaningless for logic ops, so they are masked at capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (capture) begin
      result   <= aluResult;
      carryout <= arith & aluCarryout;
      overflow <= arith & aluOverflow;
      zero     <= (aluResult == '0);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: emulates the ripple ALU behaviourally and checks decode,
// latency, results/flags, backpressure and mid-flight reset against a command-level model.
module tb_alu_sequencer;

  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmdValid;
  logic         cmdReady;
  logic [2:0]   command;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic [W-1:0] aluA;
  logic [W-1:0] aluB;
  logic [2:0]   aluOperation;
  logic         aluInvertA;
  logic         aluInvertB;
  logic         aluCarryin;
  logic [W-1:0] aluResult;
  logic         aluCarryout;
  logic         aluOverflow;
  logic         rspValid;
  logic         rspReady;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;
  logic [1:0]   fsm_state;

  int tests = 0;
  int fails = 0;

  // Expected {result, carryout, overflow, zero} per accepted command.
  logic [W+2:0] exp_q[$];
  // Expected {operation, invertA, invertB, carryin} per command code.
  logic [5:0]   dec_tab[8];

  alu_sequencer #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .command(command),
    .operandA(operandA), .operandB(operandB),
    .aluA(aluA), .aluB(aluB), .aluOperation(aluOperation),
    .aluInvertA(aluInvertA), .aluInvertB(aluInvertB), .aluCarryin(aluCarryin),
    .aluResult(aluResult), .aluCarryout(aluCarryout), .aluOverflow(aluOverflow),
    .rspValid(rspValid), .rspReady(rspReady),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural ripple ALU driven by the sequencer's registered controls.
  logic [W-1:0] ea, eb;
  logic [W:0]   esum;
  logic         eovf;
  always_comb begin
    ea          = aluInvertA ? ~aluA : aluA;
    eb          = aluInvertB ? ~aluB : aluB;
    esum        = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, aluCarryin};
    eovf        = (ea[W-1] == eb[W-1]) && (esum[W-1] != ea[W-1]);
    aluCarryout = esum[W];
    aluOverflow = eovf;
    case (aluOperation)
      3'd0:    aluResult = esum[W-1:0];
      3'd1:    aluResult = ea ^ eb;
      3'd2:    aluResult = {{(W-1){1'b0}}, esum[W-1] ^ eovf};
      3'd3:    aluResult = ea & eb;
      3'd4:    aluResult = ea | eb;
      default: aluResult = '0;
    endcase
  end

  // Command-level reference: plain arithmetic from the command definitions.
  function automatic logic [W+2:0] ref_model(input logic [2:0] cmd, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c, o;
    longint       sa, sb, d;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; o = 1'b0;
    case (cmd)
      3'd0: begin
        r = a + b;
        c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
        d = sa + sb;
        o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      end
      3'd1, 3'd3: begin
        r = (cmd == 3'd1) ? a - b : ((sa < sb) ? 32'd1 : 32'd0);
        c = (a >= b);
        d = sa - sb;
        o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      end
      3'd2: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, c, o, (r == '0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: present a command at a negedge, wait (bounded) for acceptance,
  // then check the registered operands and decoded controls.
  task automatic send_cmd(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!cmdReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'd1, 64'd0);
    command  = cmd;
    operandA = a;
    operandB = b;
    cmdValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    exp_q.push_back(ref_model(cmd, a, b));
    check("alu_a", 64'(aluA), 64'(a));
    check("alu_b", 64'(aluB), 64'(b));
    check("ctrl", 64'({aluOperation, aluInvertA, aluInvertB, aluCarryin}), 64'(dec_tab[cmd]));
  endtask

  // Called at the negedge right after the accept edge: response must appear
  // exactly SETTLE edges after acceptance.
  task automatic expect_rsp();
    logic [W+2:0] e;
    for (int k = 0; k < SETTLE; k++) begin
      check("rsp_early", 64'(rspValid), 64'd0);
      check("busy_ready", 64'(cmdReady), 64'd0);
      @(negedge clk);
    end
    check("rsp_valid", 64'(rspValid), 64'd1);
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("result", 64'(result), 64'(e[W+2:3]));
      check("flags", 64'({carryout, overflow, zero}), 64'(e[2:0]));
    end
  endtask

  task automatic expect_idle();
    @(negedge clk);
    check("rsp_one_cycle", 64'(rspValid), 64'd0);
    check("idle_ready", 64'(cmdReady), 64'd1);
  endtask

  logic [W-1:0] ra, rb, held_a;
  logic [W+2:0] held_e;
  logic [2:0]   rc;

  initial begin
    dec_tab[0] = 6'b000_000;  // ADD
    dec_tab[1] = 6'b000_011;  // SUB
    dec_tab[2] = 6'b001_000;  // XOR
    dec_tab[3] = 6'b010_011;  // SLT
    dec_tab[4] = 6'b011_000;  // AND
    dec_tab[5] = 6'b100_110;  // NAND
    dec_tab[6] = 6'b011_110;  // NOR
    dec_tab[7] = 6'b100_000;  // OR

    reset = 1'b1; cmdValid = 1'b0; command = 3'd0;
    operandA = '0; operandB = '0; rspReady = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(cmdReady), 64'd1);
    check("rst_valid", 64'(rspValid), 64'd0);
    check("rst_outs", 64'({aluA, aluOperation, aluInvertA, aluInvertB, aluCarryin}), 64'd0);
    check("rst_result", 64'({result, carryout, overflow, zero}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed test plan
    send_cmd(3'd0, 32'h7FFF_FFFF, 32'h0000_0001); expect_rsp(); expect_idle();
    send_cmd(3'd1, 32'h0000_0005, 32'h0000_0005); expect_rsp(); expect_idle();
    send_cmd(3'd3, 32'hFFFF_FFFF, 32'h0000_0001); expect_rsp(); expect_idle();
    send_cmd(3'd3, 32'h0000_0001, 32'hFFFF_FFFF); expect_rsp(); expect_idle();
    send_cmd(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00); expect_rsp(); expect_idle();
    send_cmd(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00); expect_rsp(); expect_idle();
    check("nor_value", 64'(result), 64'h0000_000F_000F);

    // Backpressure: response held, new commands ignored
    rspReady = 1'b0;
    send_cmd(3'd2, 32'h1234_5678, 32'h0F0F_0F0F);
    held_e = exp_q[0];
    held_a = 32'h1234_5678;
    expect_rsp();
    for (int i = 0; i < 10; i++) begin
      cmdValid = 1'b1;
      command  = 3'd7;
      operandA = $urandom;
      operandB = $urandom;
      @(negedge clk);
      check("bp_valid", 64'(rspValid), 64'd1);
      check("bp_ready", 64'(cmdReady), 64'd0);
      check("bp_result", 64'(result), 64'(held_e[W+2:3]));
      check("bp_no_accept", 64'(aluA), 64'(held_a));
    end
    cmdValid = 1'b0;
    rspReady = 1'b1;
    expect_idle();

    // Reset two cycles into WAIT
    send_cmd(3'd1, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(cmdReady), 64'd1);
    check("mid_rst_valid", 64'(rspValid), 64'd0);
    check("mid_rst_ctrl", 64'({aluOperation, aluInvertA, aluInvertB, aluCarryin}), 64'd0);
    check("mid_rst_ops", 64'({aluA, aluB}), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < SETTLE + 4; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 64'(rspValid), 64'd0);
    end

    // Randomized commands with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      send_cmd(rc, ra, rb);
      expect_rsp();
      expect_idle();
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
